// File: rtl/fx3_gpif_pkg.sv
// rtl/fx3_gpif_pkg.sv - shared types and flag polarities for the FX3 GPIF receiver
package fx3_gpif_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SWITCH,
        STALL
    } fsmState_t;

    typedef enum logic {
        EMPTY,
        DRAINING
    } bufState_t;

    localparam logic FX3_READY     = 1'b0;
    localparam logic FX3_NOT_READY = 1'b1;

endpackage

// File: rtl/fx3_gpif_receiver_checker.sv
// rtl/fx3_gpif_receiver_checker.sv - incrementing test-pattern checker with saturating error count
module testPatternChecker #(
    parameter logic [15:0] TEST_STEP = 16'd64
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        enable,
    input  logic        valid,
    input  logic [15:0] data,
    output logic [15:0] errorCount
);

    logic        armed;
    logic [15:0] reference;

    // First word after enable only loads the reference; later words are compared, then resync.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            armed      <= 1'b0;
            reference  <= 16'h0000;
            errorCount <= 16'h0000;
        end else if (!enable) begin
            armed <= 1'b0;
        end else if (valid) begin
            armed     <= 1'b1;
            reference <= data;
            if (armed && (data != 16'(reference + TEST_STEP)) && (errorCount != 16'hFFFF)) begin
                errorCount <= errorCount + 16'd1;
            end
        end
    end

endmodule

// File: rtl/fx3_gpif_receiver.sv
// rtl/fx3_gpif_receiver.sv - FX3 thread-0 double-buffered DMA sink emulation
module fx3_gpif_receiver
    import fx3_gpif_pkg::*;
#(
    parameter int          BUFFER_WORDS    = 8192,
    parameter int          WATERMARK_WORDS = 6,
    parameter int          DRAIN_CYCLES    = 4096,
    parameter int          SWITCH_CYCLES   = 3,
    parameter logic [15:0] TEST_STEP       = 16'd64
) (
    input  logic        fx3_clock,
    input  logic        fx3_nReset,
    input  logic [15:0] fx3_databus,
    input  logic        fx3_nWrite,
    input  logic        fx3_nTestmode,
    output logic        fx3_nReady,
    output logic        fx3_th0Ready,
    output logic        fx3_th0Watermark,
    output logic [31:0] wordCount,
    output logic [15:0] overrunCount,
    output logic [15:0] testErrorCount
);

    localparam int PTR_W   = $clog2(BUFFER_WORDS);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int SW_W    = $clog2(SWITCH_CYCLES) + 1;

    localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(BUFFER_WORDS - 1);
    localparam logic [PTR_W:0]     BUF_SIZE   = (PTR_W + 1)'(BUFFER_WORDS);
    localparam logic [PTR_W:0]     WM_LEVEL   = (PTR_W + 1)'(WATERMARK_WORDS);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [SW_W-1:0]    SW_LAST    = SW_W'(SWITCH_CYCLES - 1);

    fsmState_t          state;
    fsmState_t          stateNext;
    logic [PTR_W-1:0]   writePtr;
    logic               activeBuf;
    logic [SW_W-1:0]    switchCount;
    bufState_t          bufStateA;
    bufState_t          bufStateB;
    logic [DRAIN_W-1:0] drainTimerA;
    logic [DRAIN_W-1:0] drainTimerB;
    logic               accept;
    logic               lastWord;
    logic               otherFree;
    logic [PTR_W:0]     remaining;

    assign accept    = (state == FILL) && !fx3_nWrite;
    assign lastWord  = accept && (writePtr == PTR_LAST);
    assign remaining = BUF_SIZE - {1'b0, writePtr};

    // The standby buffer counts as free on the edge its drain timer reaches zero.
    always_comb begin
        otherFree = 1'b0;
        if (activeBuf == 1'b0) begin
            otherFree = (bufStateB == EMPTY) || (drainTimerB == DRAIN_ONE);
        end else begin
            otherFree = (bufStateA == EMPTY) || (drainTimerA == DRAIN_ONE);
        end
    end

    // Main FSM state register.
    always_ff @(posedge fx3_clock) begin
        if (!fx3_nReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Main FSM next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = FILL;
            FILL:    if (lastWord) stateNext = otherFree ? SWITCH : STALL;
            SWITCH:  if (switchCount == SW_LAST) stateNext = FILL;
            STALL:   if (otherFree) stateNext = SWITCH;
            default: stateNext = IDLE;
        endcase
    end

    // Write pointer, switch latency counter, active buffer select and traffic counters.
    always_ff @(posedge fx3_clock) begin
        if (!fx3_nReset) begin
            writePtr     <= '0;
            activeBuf    <= 1'b0;
            switchCount  <= '0;
            wordCount    <= 32'd0;
            overrunCount <= 16'h0000;
        end else begin
            if (accept) begin
                wordCount <= wordCount + 32'd1;
                writePtr  <= lastWord ? '0 : writePtr + PTR_W'(1);
            end
            if (!fx3_nWrite && (state != FILL) && (overrunCount != 16'hFFFF)) begin
                overrunCount <= overrunCount + 16'd1;
            end
            switchCount <= (state == SWITCH) ? switchCount + SW_W'(1) : '0;
            if ((state == SWITCH) && (stateNext == FILL)) begin
                activeBuf <= ~activeBuf;
            end
        end
    end

    // Buffer A drain emulation: committed on its last word, empty when the timer hits zero.
    always_ff @(posedge fx3_clock) begin
        if (!fx3_nReset) begin
            bufStateA   <= EMPTY;
            drainTimerA <= '0;
        end else if (lastWord && (activeBuf == 1'b0)) begin
            bufStateA   <= DRAINING;
            drainTimerA <= DRAIN_LOAD;
        end else if (bufStateA == DRAINING) begin
            drainTimerA <= drainTimerA - DRAIN_ONE;
            if (drainTimerA == DRAIN_ONE) bufStateA <= EMPTY;
        end
    end

    // Buffer B drain emulation, mirror of buffer A.
    always_ff @(posedge fx3_clock) begin
        if (!fx3_nReset) begin
            bufStateB   <= EMPTY;
            drainTimerB <= '0;
        end else if (lastWord && (activeBuf == 1'b1)) begin
            bufStateB   <= DRAINING;
            drainTimerB <= DRAIN_LOAD;
        end else if (bufStateB == DRAINING) begin
            drainTimerB <= drainTimerB - DRAIN_ONE;
            if (drainTimerB == DRAIN_ONE) bufStateB <= EMPTY;
        end
    end

    // Flags follow the registered state, so they trail the sampled write by one edge.
    always_ff @(posedge fx3_clock) begin
        if (!fx3_nReset) begin
            fx3_nReady       <= FX3_NOT_READY;
            fx3_th0Ready     <= FX3_NOT_READY;
            fx3_th0Watermark <= 1'b1;
        end else begin
            fx3_nReady       <= (state == FILL) ? FX3_READY : FX3_NOT_READY;
            fx3_th0Ready     <= (state == FILL) ? FX3_READY : FX3_NOT_READY;
            fx3_th0Watermark <= (state != FILL) || (remaining <= WM_LEVEL);
        end
    end

    testPatternChecker #(
        .TEST_STEP(TEST_STEP)
    ) u_checker (
        .clock     (fx3_clock),
        .nReset    (fx3_nReset),
        .enable    (~fx3_nTestmode),
        .valid     (accept),
        .data      (fx3_databus),
        .errorCount(testErrorCount)
    );

endmodule

// File: tb/tb_fx3_gpif_receiver.sv
// tb/tb_fx3_gpif_receiver.sv - self-checking bench for fx3_gpif_receiver
module tb_fx3_gpif_receiver;

    localparam int          BW   = 32;
    localparam int          WM   = 6;
    localparam int          DR   = 100;
    localparam int          SW   = 3;
    localparam logic [15:0] STEP = 16'd64;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        nRst = 1'b0;
    logic        nWr  = 1'b1;
    logic        nTm  = 1'b1;
    logic [15:0] data = 16'h0000;
    logic        nReady, th0Ready, wm;
    logic [31:0] wordCount;
    logic [15:0] overrunCount, testErrorCount;

    fx3_gpif_receiver #(
        .BUFFER_WORDS(BW), .WATERMARK_WORDS(WM), .DRAIN_CYCLES(DR),
        .SWITCH_CYCLES(SW), .TEST_STEP(STEP)
    ) dut (
        .fx3_clock(clk), .fx3_nReset(nRst), .fx3_databus(data),
        .fx3_nWrite(nWr), .fx3_nTestmode(nTm),
        .fx3_nReady(nReady), .fx3_th0Ready(th0Ready), .fx3_th0Watermark(wm),
        .wordCount(wordCount), .overrunCount(overrunCount), .testErrorCount(testErrorCount)
    );

    logic        sRst = 1'b0;
    logic        sWr  = 1'b1;
    logic        sNReady, sRdy, sWm;
    logic [31:0] sWords;
    logic [15:0] sOver, sErr;

    fx3_gpif_receiver #(
        .BUFFER_WORDS(16), .WATERMARK_WORDS(4), .DRAIN_CYCLES(70000),
        .SWITCH_CYCLES(2), .TEST_STEP(16'd1)
    ) satDut (
        .fx3_clock(clk), .fx3_nReset(sRst), .fx3_databus(16'h0000),
        .fx3_nWrite(sWr), .fx3_nTestmode(1'b1),
        .fx3_nReady(sNReady), .fx3_th0Ready(sRdy), .fx3_th0Watermark(sWm),
        .wordCount(sWords), .overrunCount(sOver), .testErrorCount(sErr)
    );

    int compared   = 0;
    int mismatched = 0;

    longint      edgeNo = 0;
    longint      fillFrom = 1;
    longint      emptyAt [2] = '{0, 0};
    int          mPtr = 0;
    int          mActive = 0;
    logic [31:0] mWords = 0;
    logic [15:0] mOver = 0, mErr = 0, mRef = 0;
    bit          mArmed = 0;
    bit          expNRdy = 1, expWm = 1, pendNRdy = 1, pendWm = 1;

    typedef struct {
        logic [15:0] d;
        logic        tm;
        logic [15:0] expErr;
    } patVec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, exp, edgeNo);
        end
    endtask

    // Timestamp model: the receiver is filling from edge fillFrom on; a buffer becomes
    // reusable at emptyAt; a full buffer resumes filling at max(now, other free) + SW.
    task automatic cycle(input logic r, input logic w, input logic tm, input logic [15:0] d);
        bit inBefore, inAfter;
        nRst = r; nWr = w; nTm = tm; data = d;
        @(posedge clk);
        edgeNo++;
        expNRdy = pendNRdy;
        expWm   = pendWm;
        if (!r) begin
            fillFrom = edgeNo + 1;
            emptyAt[0] = 0; emptyAt[1] = 0;
            mPtr = 0; mActive = 0; mWords = 0; mOver = 0; mErr = 0; mRef = 0; mArmed = 0;
            expNRdy = 1; expWm = 1;
        end else begin
            inBefore = (edgeNo - 1 >= fillFrom);
            if (tm) mArmed = 0;
            if (!w) begin
                if (inBefore) begin
                    mWords++;
                    if (!tm) begin
                        if (mArmed && d != 16'(mRef + STEP) && mErr != 16'hFFFF) mErr++;
                        mRef = d;
                        mArmed = 1;
                    end
                    mPtr++;
                    if (mPtr == BW) begin
                        mPtr = 0;
                        emptyAt[mActive] = edgeNo + DR;
                        fillFrom = ((edgeNo > emptyAt[1 - mActive]) ? edgeNo : emptyAt[1 - mActive]) + SW;
                        mActive = 1 - mActive;
                    end
                end else if (mOver != 16'hFFFF) begin
                    mOver++;
                end
            end
        end
        inAfter  = (edgeNo >= fillFrom);
        pendNRdy = !inAfter;
        pendWm   = !inAfter || (BW - mPtr <= WM);
        #1;
        chk("nReady", 32'(nReady), 32'(expNRdy));
        chk("th0Ready", 32'(th0Ready), 32'(expNRdy));
        chk("watermark", 32'(wm), 32'(expWm));
        chk("wordCount", wordCount, mWords);
        chk("overrunCount", 32'(overrunCount), 32'(mOver));
        chk("testErrorCount", 32'(testErrorCount), 32'(mErr));
    endtask

    task automatic waitReady(input int bound, output int n);
        n = 0;
        while (nReady !== 1'b0 && n < bound) begin
            cycle(1, 1, 1, 16'h0000);
            n++;
        end
        chk("waitReady", 32'(nReady), 32'd0);
    endtask

    initial begin
        sRst = 1'b0; sWr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sRst = 1'b1; sWr = 1'b0;
    end

    initial begin
        patVec_t     pv [10];
        int          n, notReady, wprob;
        logic [15:0] pat, d;
        logic        tmState, w, r;

        pv[0] = '{16'h0000, 1'b0, 16'd0};
        pv[1] = '{16'h0040, 1'b0, 16'd0};
        pv[2] = '{16'h0080, 1'b0, 16'd0};
        pv[3] = '{16'h00FF, 1'b0, 16'd1};
        pv[4] = '{16'h013F, 1'b0, 16'd1};
        pv[5] = '{16'h1234, 1'b1, 16'd1};
        pv[6] = '{16'hFFC0, 1'b0, 16'd1};
        pv[7] = '{16'h0000, 1'b0, 16'd1};
        pv[8] = '{16'h0040, 1'b0, 16'd1};
        pv[9] = '{16'h0000, 1'b0, 16'd2};

        // reset and release
        repeat (3) cycle(0, 1, 1, 16'h0000);
        chk("rstNReady", 32'(nReady), 32'd1);
        chk("rstWm", 32'(wm), 32'd1);
        chk("rstWords", wordCount, 32'd0);
        cycle(1, 1, 1, 16'h0000);
        chk("edge1NReady", 32'(nReady), 32'd1);
        cycle(1, 1, 1, 16'h0000);
        chk("edge2NReady", 32'(nReady), 32'd0);
        chk("edge2Th0Ready", 32'(th0Ready), 32'd0);
        chk("edge2Wm", 32'(wm), 32'd0);

        // watermark and buffer switch on A
        for (int i = 0; i < 26; i++) cycle(1, 0, 1, 16'(i));
        chk("wm26Lag", 32'(wm), 32'd0);
        cycle(1, 1, 1, 16'h0000);
        chk("wm26", 32'(wm), 32'd1);
        chk("nReady26", 32'(nReady), 32'd0);
        for (int i = 26; i < 32; i++) cycle(1, 0, 1, 16'(i));
        chk("words32", wordCount, 32'd32);
        notReady = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(1, 1, 1, 16'h0000);
            if (nReady) notReady++;
        end
        chk("switchGap", 32'(notReady), 32'(SW));

        // fill B, then overrun while stalled on A's drain
        for (int i = 0; i < 32; i++) cycle(1, 0, 1, 16'(i));
        chk("words64", wordCount, 32'd64);
        for (int i = 0; i < 10; i++) cycle(1, 0, 1, 16'(i));
        chk("stallOverrun", 32'(overrunCount), 32'd10);
        chk("stallNReady", 32'(nReady), 32'd1);
        waitReady(200, n);
        chk("stallLength", 32'(n), 32'd50);

        // test pattern table
        foreach (pv[i]) begin
            cycle(1, 0, pv[i].tm, pv[i].d);
            chk($sformatf("pattern[%0d]", i), 32'(testErrorCount), 32'(pv[i].expErr));
        end

        // reset mid-buffer at pointer 20
        for (int i = 0; i < 10; i++) cycle(1, 0, 1, 16'(i));
        cycle(0, 1, 1, 16'h0000);
        chk("midRstWords", wordCount, 32'd0);
        chk("midRstOverrun", 32'(overrunCount), 32'd0);
        chk("midRstErr", 32'(testErrorCount), 32'd0);
        chk("midRstFlags", {29'd0, nReady, th0Ready, wm}, 32'h7);
        cycle(1, 1, 1, 16'h0000);
        chk("midRstEdge1", 32'(nReady), 32'd1);
        cycle(1, 1, 1, 16'h0000);
        chk("midRstEdge2", 32'(nReady), 32'd0);

        // randomized traffic against the model
        pat = 16'h0000;
        tmState = 1'b0;
        wprob = 60;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: wprob = 20;
                    1: wprob = 60;
                    2: wprob = 95;
                    default: wprob = 100;
                endcase
            end
            if ($urandom_range(0, 99) == 0) tmState = ~tmState;
            r = ($urandom_range(0, 699) != 0);
            w = ($urandom_range(0, 99) < wprob) ? 1'b0 : 1'b1;
            d = ($urandom_range(0, 9) < 7) ? pat : 16'($urandom);
            if (!w) pat = 16'(d + STEP);
            cycle(r, w, tmState, d);
        end

        // let the saturation instance accumulate overruns past 2^16
        while (edgeNo < 66500) cycle(1, 1, 1, 16'h0000);
        chk("satOverrun", 32'(sOver), 32'h0000FFFF);
        chk("satWords", sWords, 32'd32);
        chk("satNReady", 32'(sNReady), 32'd1);
        chk("satErr", 32'(sErr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
